// File: rtl/router_switch_alloc_3port_pkg.sv
// Shared constants for the 3-port switch allocator.
// Port codes, input/output indices, lock states, helpers.
package router_switch_alloc_3port_pkg;

  localparam int NP = 3;

  localparam logic [2:0] EMPTY          = 3'b000;
  localparam logic [2:0] OUT_X1_PORT    = 3'b001;
  localparam logic [2:0] OUT_Y1_PORT    = 3'b010;
  localparam logic [2:0] OUT_LOCAL_PORT = 3'b100;

  localparam int IN_X     = 0;
  localparam int IN_Y     = 1;
  localparam int IN_LOCAL = 2;

  localparam int OUT_X1    = 0;
  localparam int OUT_Y1    = 1;
  localparam int OUT_LOCAL = 2;

  typedef enum logic {
    LOCK_FREE = 1'b0,
    LOCK_BUSY = 1'b1
  } lock_e;

  // One-hot code of output o.
  function automatic logic [2:0] port_code(input int o);
    return 3'(1 << o);
  endfunction

  // Index increment modulo 3.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

// File: rtl/router_switch_alloc_3port_if.sv
// Request/grant/credit bundle between inputs and allocator.
// master: request side; slave: allocator side.
interface router_switch_alloc_3port_if;
  import router_switch_alloc_3port_pkg::*;

  logic [NP-1:0]   req_valid;
  logic [3*NP-1:0] req_port;
  logic [NP-1:0]   req_tail;
  logic [NP-1:0]   credit_in;
  logic [NP-1:0]   gnt;
  logic [3*NP-1:0] xbar_sel;
  logic [NP-1:0]   out_valid;
  logic            credit_err;

  modport master (
    output req_valid, req_port, req_tail, credit_in,
    input  gnt, xbar_sel, out_valid, credit_err
  );

  modport slave (
    input  req_valid, req_port, req_tail, credit_in,
    output gnt, xbar_sel, out_valid, credit_err
  );

endinterface

// File: rtl/router_switch_alloc_3port_rr_arb3.sv
// 3-request round-robin picker, combinational.
// req/ptr in; one-hot gnt and its index out.
module rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] idx
);

  always_comb begin
    int p;
    int j;
    logic found;
    gnt   = '0;
    found = 1'b0;
    p     = (ptr == 2'd3) ? 0 : int'(ptr);
    for (int k = 0; k < 3; k++) begin
      j = (p + k) % 3;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    idx = 2'd0;
    unique case (1'b1)
      gnt[0]:  idx = 2'd0;
      gnt[1]:  idx = 2'd1;
      gnt[2]:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/router_switch_alloc_3port.sv
// Switch allocator: per-output RR, packet lock, credits.
// Ports: clk, rst, bus (slave); ROUTER_ALLOC_STATS_EN adds pkt_cnt/stall_cnt.
module router_switch_alloc_3port
  import router_switch_alloc_3port_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input logic clk,
  input logic rst,
  router_switch_alloc_3port_if.slave bus
`ifdef ROUTER_ALLOC_STATS_EN
  ,
  output logic [47:0] pkt_cnt,
  output logic [15:0] stall_cnt
`endif
);

  lock_e         lock_q   [NP];
  lock_e         lock_d   [NP];
  logic [1:0]    owner_q  [NP];
  logic [1:0]    owner_d  [NP];
  logic [1:0]    rr_ptr_q [NP];
  logic [1:0]    rr_ptr_d [NP];
  logic [CW-1:0] cred_q   [NP];
  logic [CW-1:0] cred_d   [NP];
  logic          credit_err_q;
  logic          credit_err_d;

  logic [2:0] reqm    [NP];
  logic [2:0] arb_req [NP];
  logic [2:0] arb_gnt [NP];
  logic [1:0] arb_idx [NP];

  logic [NP-1:0]   gnt_c;
  logic [3*NP-1:0] xbar_c;
  logic [NP-1:0]   ov_c;

  // reqm[o][i]: input i asks for exactly output o
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      reqm[o] = '0;
      for (int i = 0; i < NP; i++)
        reqm[o][i] = bus.req_valid[i] &&
                     (bus.req_port[3*i +: 3] == port_code(o));
      arb_req[o] = (cred_q[o] != '0) ? reqm[o] : 3'b000;
    end
  end

  for (genvar g = 0; g < NP; g++) begin : g_arb
    rr_arb3 u_arb (
      .req (arb_req[g]),
      .ptr (rr_ptr_q[g]),
      .gnt (arb_gnt[g]),
      .idx (arb_idx[g])
    );
  end

  always_comb begin
    logic [1:0] w;
    logic       wv;
    gnt_c        = '0;
    xbar_c       = '0;
    ov_c         = '0;
    credit_err_d = credit_err_q;
    for (int o = 0; o < NP; o++) begin
      lock_d[o]   = lock_q[o];
      owner_d[o]  = owner_q[o];
      rr_ptr_d[o] = rr_ptr_q[o];
      cred_d[o]   = cred_q[o];
      if (lock_q[o] == LOCK_FREE) begin
        wv = |arb_gnt[o];
        w  = arb_idx[o];
      end else begin
        wv = (cred_q[o] != '0) && reqm[o][owner_q[o]];
        w  = owner_q[o];
      end
      if (!rst && wv) begin
        gnt_c[w]         = 1'b1;
        xbar_c[3*o +: 3] = 3'b001 << w;
        ov_c[o]          = 1'b1;
        if (bus.req_tail[w]) begin
          lock_d[o]   = LOCK_FREE;
          rr_ptr_d[o] = inc3(w);
        end else if (lock_q[o] == LOCK_FREE) begin
          lock_d[o]  = LOCK_BUSY;
          owner_d[o] = w;
        end
      end
      // A return at full count with no send is an overflow
      if (bus.credit_in[o] && !ov_c[o] &&
          cred_q[o] == CW'(CREDITS))
        credit_err_d = 1'b1;
      else
        cred_d[o] = cred_q[o] + CW'(bus.credit_in[o])
                    - CW'(ov_c[o]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NP; o++) begin
        lock_q[o]   <= LOCK_FREE;
        owner_q[o]  <= 2'd0;
        rr_ptr_q[o] <= 2'd0;
        cred_q[o]   <= CW'(CREDITS);
      end
      credit_err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        lock_q[o]   <= lock_d[o];
        owner_q[o]  <= owner_d[o];
        rr_ptr_q[o] <= rr_ptr_d[o];
        cred_q[o]   <= cred_d[o];
      end
      credit_err_q <= credit_err_d;
    end
  end

  assign bus.gnt        = gnt_c;
  assign bus.xbar_sel   = xbar_c;
  assign bus.out_valid  = ov_c;
  assign bus.credit_err = credit_err_q;

`ifdef ROUTER_ALLOC_STATS_EN
  logic [15:0] pkt_q [NP];
  logic [15:0] pkt_d [NP];
  logic [15:0] stall_q;
  logic [15:0] stall_d;
  logic [2:0]  legal;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      legal[i] = (bus.req_port[3*i +: 3] == OUT_X1_PORT) ||
                 (bus.req_port[3*i +: 3] == OUT_Y1_PORT) ||
                 (bus.req_port[3*i +: 3] == OUT_LOCAL_PORT);
    end
    for (int o = 0; o < NP; o++)
      pkt_d[o] = pkt_q[o] +
                 16'(|(xbar_c[3*o +: 3] & bus.req_tail));
    stall_d = stall_q;
    if (|(legal & bus.req_valid & ~gnt_c) && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NP; o++) pkt_q[o] <= '0;
      stall_q <= '0;
    end else begin
      for (int o = 0; o < NP; o++) pkt_q[o] <= pkt_d[o];
      stall_q <= stall_d;
    end
  end

  assign pkt_cnt   = {pkt_q[2], pkt_q[1], pkt_q[0]};
  assign stall_cnt = stall_q;
`endif

endmodule
